// File: rtl/regfile_wr_arbiter.sv
// Round-robin arbiter sharing one register-file write port among NUM_REQ producers.
// Registered issue stage; writes to out-of-range destinations are dropped and flagged.
module regfile_wr_arbiter #(
  parameter int unsigned NUM_REQ  = 3,
  parameter int unsigned DATA_W   = 16,
  parameter int unsigned ADDR_W   = 16,
  parameter int unsigned NUM_REGS = 12
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [NUM_REQ-1:0]           req_valid,
  input  logic [NUM_REQ*ADDR_W-1:0]    req_dest,
  input  logic [NUM_REQ*DATA_W-1:0]    req_data,
  output logic [NUM_REQ-1:0]           req_ready,
  input  logic                         wr_stall,
  output logic                         wr_en,
  output logic [ADDR_W-1:0]            wr_dest,
  output logic [DATA_W-1:0]            wr_val,
  output logic                         err_valid,
  output logic [$clog2(NUM_REQ)-1:0]   err_id
);

  localparam int unsigned ID_W  = $clog2(NUM_REQ);
  localparam int unsigned SUM_W = ID_W + 1;

  logic [ID_W-1:0]   r_rr_ptr;
  logic              r_wr_en;
  logic [ADDR_W-1:0] r_wr_dest;
  logic [DATA_W-1:0] r_wr_val;
  logic              r_err_valid;
  logic [ID_W-1:0]   r_err_id;

  logic [ID_W-1:0]   w_gnt_idx;
  logic [ID_W-1:0]   w_idx;
  logic [ID_W-1:0]   w_next_ptr;
  logic [SUM_W-1:0]  w_sum;
  logic              w_found;
  logic              w_xfer;
  logic              w_legal;
  logic [ADDR_W-1:0] w_sel_dest;
  logic [DATA_W-1:0] w_sel_data;

  // Search upward from r_rr_ptr with wrap; no grants in reset or while stalled.
  always_comb begin
    w_found   = 1'b0;
    w_gnt_idx = '0;
    w_sum     = '0;
    w_idx     = '0;
    req_ready = '0;
    for (int k = 0; k < int'(NUM_REQ); k++) begin
      w_sum = SUM_W'(r_rr_ptr) + SUM_W'(k);
      if (w_sum >= SUM_W'(NUM_REQ)) begin
        w_sum = w_sum - SUM_W'(NUM_REQ);
      end
      w_idx = w_sum[ID_W-1:0];
      if (!w_found && req_valid[w_idx]) begin
        w_found   = 1'b1;
        w_gnt_idx = w_idx;
      end
    end
    if (rst && !wr_stall && w_found) begin
      req_ready[w_gnt_idx] = 1'b1;
    end
  end

  // Payload mux for the granted requester.
  always_comb begin
    w_sel_dest = '0;
    w_sel_data = '0;
    for (int i = 0; i < int'(NUM_REQ); i++) begin
      if (w_gnt_idx == ID_W'(i)) begin
        w_sel_dest = req_dest[i*ADDR_W +: ADDR_W];
        w_sel_data = req_data[i*DATA_W +: DATA_W];
      end
    end
  end

  assign w_xfer     = |(req_valid & req_ready);
  assign w_legal    = (w_sel_dest < ADDR_W'(NUM_REGS));
  assign w_next_ptr = (w_gnt_idx == ID_W'(NUM_REQ - 1)) ? '0 : w_gnt_idx + 1'b1;

  // Pointer advance and issue stage; wr_dest/wr_val hold unless a legal write issues.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_rr_ptr    <= '0;
      r_wr_en     <= 1'b0;
      r_wr_dest   <= '0;
      r_wr_val    <= '0;
      r_err_valid <= 1'b0;
      r_err_id    <= '0;
    end else begin
      r_wr_en     <= 1'b0;
      r_err_valid <= 1'b0;
      if (w_xfer) begin
        r_rr_ptr <= w_next_ptr;
        if (w_legal) begin
          r_wr_en   <= 1'b1;
          r_wr_dest <= w_sel_dest;
          r_wr_val  <= w_sel_data;
        end else begin
          r_err_valid <= 1'b1;
          r_err_id    <= w_gnt_idx;
        end
      end
    end
  end

  assign wr_en     = r_wr_en;
  assign wr_dest   = r_wr_dest;
  assign wr_val    = r_wr_val;
  assign err_valid = r_err_valid;
  assign err_id    = r_err_id;

endmodule

// File: tb/tb_regfile_wr_arbiter.sv
// Directed bench for regfile_wr_arbiter: reset, round-robin, wrap, illegal dest,
// stall and mid-operation reset, each with hand-computed expectations.
module tb_regfile_wr_arbiter;

  logic        clk;
  logic        rst;
  logic [2:0]  req_valid;
  logic [47:0] req_dest;
  logic [47:0] req_data;
  logic [2:0]  req_ready;
  logic        wr_stall;
  logic        wr_en;
  logic [15:0] wr_dest;
  logic [15:0] wr_val;
  logic        err_valid;
  logic [1:0]  err_id;

  int checks;
  int failures;

  regfile_wr_arbiter dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_dest  (req_dest),
    .req_data  (req_data),
    .req_ready (req_ready),
    .wr_stall  (wr_stall),
    .wr_en     (wr_en),
    .wr_dest   (wr_dest),
    .wr_val    (wr_val),
    .err_valid (err_valid),
    .err_id    (err_id)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst       = 1'b0;
    wr_stall  = 1'b0;
    req_valid = 3'b111;
    req_dest  = {16'd3, 16'd2, 16'd1};
    req_data  = {16'h00C3, 16'h00B2, 16'h00A1};
    tick();
    tick();
    checks++; if (req_ready !== 3'b000) begin failures++; $display("FAIL reset_ready act=%b exp=000", req_ready); end
    checks++; if (wr_en !== 1'b0 || err_valid !== 1'b0) begin failures++; $display("FAIL reset_en_err act=%b%b exp=00", wr_en, err_valid); end
    checks++; if (wr_dest !== 16'd0 || wr_val !== 16'd0 || err_id !== 2'd0) begin failures++; $display("FAIL reset_regs act=%h/%h/%0d exp=0/0/0", wr_dest, wr_val, err_id); end
    rst = 1'b1;
    #1;
    checks++; if (req_ready !== 3'b001) begin failures++; $display("FAIL reset_first_grant act=%b exp=001", req_ready); end
  endtask

  task automatic test_round_robin();
    logic [15:0] exp_data [3];
    logic [2:0]  exp_ready;
    exp_data[0] = 16'h00A1;
    exp_data[1] = 16'h00B2;
    exp_data[2] = 16'h00C3;
    for (int c = 0; c < 6; c++) begin
      exp_ready = 3'b001 << (c % 3);
      checks++; if (req_ready !== exp_ready) begin failures++; $display("FAIL rr_ready c=%0d act=%b exp=%b", c, req_ready, exp_ready); end
      tick();
      checks++; if (wr_en !== 1'b1 || wr_dest !== 16'((c % 3) + 1) || wr_val !== exp_data[c % 3]) begin
        failures++; $display("FAIL rr_write c=%0d act=%b/%h/%h exp=1/%h/%h", c, wr_en, wr_dest, wr_val, 16'((c % 3) + 1), exp_data[c % 3]);
      end
    end
  endtask

  task automatic test_wrap();
    logic [2:0]  exp_ready;
    logic [15:0] exp_dest;
    req_valid = 3'b010;
    #1;
    checks++; if (req_ready !== 3'b010) begin failures++; $display("FAIL wrap_setup act=%b exp=010", req_ready); end
    tick();
    checks++; if (wr_en !== 1'b1 || wr_dest !== 16'd2 || wr_val !== 16'h00B2) begin failures++; $display("FAIL wrap_setup_wr act=%b/%h/%h exp=1/2/b2", wr_en, wr_dest, wr_val); end
    req_valid = 3'b011;
    #1;
    for (int c = 0; c < 3; c++) begin
      exp_ready = (c == 1) ? 3'b010 : 3'b001;
      exp_dest  = (c == 1) ? 16'd2 : 16'd1;
      checks++; if (req_ready !== exp_ready) begin failures++; $display("FAIL wrap_ready c=%0d act=%b exp=%b", c, req_ready, exp_ready); end
      tick();
      checks++; if (wr_en !== 1'b1 || wr_dest !== exp_dest) begin failures++; $display("FAIL wrap_write c=%0d act=%b/%h exp=1/%h", c, wr_en, wr_dest, exp_dest); end
    end
  endtask

  task automatic test_illegal_dest();
    req_valid = 3'b010;
    req_dest  = {16'd3, 16'd12, 16'd1};
    req_data  = {16'h00C3, 16'hFFFF, 16'h00A1};
    #1;
    checks++; if (req_ready !== 3'b010) begin failures++; $display("FAIL illegal_ready act=%b exp=010", req_ready); end
    tick();
    checks++; if (wr_en !== 1'b0 || err_valid !== 1'b1 || err_id !== 2'd1) begin failures++; $display("FAIL illegal_err act=%b/%b/%0d exp=0/1/1", wr_en, err_valid, err_id); end
    checks++; if (wr_dest !== 16'd1 || wr_val !== 16'h00A1) begin failures++; $display("FAIL illegal_hold act=%h/%h exp=1/a1", wr_dest, wr_val); end
    req_valid = 3'b100;
    req_dest  = {16'd11, 16'd12, 16'd1};
    req_data  = {16'h1234, 16'hFFFF, 16'h00A1};
    #1;
    checks++; if (req_ready !== 3'b100) begin failures++; $display("FAIL edge_ready act=%b exp=100", req_ready); end
    tick();
    checks++; if (wr_en !== 1'b1 || wr_dest !== 16'd11 || wr_val !== 16'h1234 || err_valid !== 1'b0) begin
      failures++; $display("FAIL edge_write act=%b/%h/%h/%b exp=1/b/1234/0", wr_en, wr_dest, wr_val, err_valid);
    end
    req_valid = 3'b000;
    tick();
    checks++; if (wr_en !== 1'b0 || err_valid !== 1'b0) begin failures++; $display("FAIL idle_after act=%b%b exp=00", wr_en, err_valid); end
  endtask

  task automatic test_stall();
    req_dest  = {16'd3, 16'd2, 16'd1};
    req_data  = {16'h00C3, 16'h00B2, 16'h00A1};
    req_valid = 3'b001;
    #1;
    checks++; if (req_ready !== 3'b001) begin failures++; $display("FAIL stall_pre act=%b exp=001", req_ready); end
    tick();
    wr_stall  = 1'b1;
    req_valid = 3'b011;
    #1;
    checks++; if (req_ready !== 3'b000) begin failures++; $display("FAIL stall_ready act=%b exp=000", req_ready); end
    checks++; if (wr_en !== 1'b1 || wr_dest !== 16'd1) begin failures++; $display("FAIL stall_inflight act=%b/%h exp=1/1", wr_en, wr_dest); end
    for (int c = 0; c < 4; c++) begin
      tick();
      checks++; if (req_ready !== 3'b000 || wr_en !== 1'b0) begin failures++; $display("FAIL stall_hold c=%0d act=%b/%b exp=000/0", c, req_ready, wr_en); end
    end
    wr_stall = 1'b0;
    #1;
    checks++; if (req_ready !== 3'b010) begin failures++; $display("FAIL stall_release act=%b exp=010", req_ready); end
    tick();
    checks++; if (wr_en !== 1'b1 || wr_dest !== 16'd2 || wr_val !== 16'h00B2) begin failures++; $display("FAIL stall_release_wr act=%b/%h/%h exp=1/2/b2", wr_en, wr_dest, wr_val); end
    req_valid = 3'b001;
    #1;
    checks++; if (req_ready !== 3'b001) begin failures++; $display("FAIL stall_req0 act=%b exp=001", req_ready); end
    tick();
    checks++; if (wr_en !== 1'b1 || wr_dest !== 16'd1 || wr_val !== 16'h00A1) begin failures++; $display("FAIL stall_req0_wr act=%b/%h/%h exp=1/1/a1", wr_en, wr_dest, wr_val); end
    req_valid = 3'b000;
  endtask

  task automatic test_reset_mid_op();
    req_valid = 3'b010;
    #1;
    checks++; if (req_ready !== 3'b010) begin failures++; $display("FAIL rstmid_pre act=%b exp=010", req_ready); end
    rst = 1'b0;
    #1;
    checks++; if (req_ready !== 3'b000 || wr_en !== 1'b0) begin failures++; $display("FAIL rstmid_abort act=%b/%b exp=000/0", req_ready, wr_en); end
    req_valid = 3'b000;
    tick();
    tick();
    rst = 1'b1;
    for (int c = 0; c < 2; c++) begin
      tick();
      checks++; if (wr_en !== 1'b0 || err_valid !== 1'b0) begin failures++; $display("FAIL rstmid_nopulse c=%0d act=%b%b exp=00", c, wr_en, err_valid); end
    end
    req_valid = 3'b111;
    #1;
    checks++; if (req_ready !== 3'b001) begin failures++; $display("FAIL rstmid_regrant act=%b exp=001", req_ready); end
    tick();
    checks++; if (wr_en !== 1'b1 || wr_dest !== 16'd1) begin failures++; $display("FAIL rstmid_xfer act=%b/%h exp=1/1", wr_en, wr_dest); end
    rst = 1'b0;
    #1;
    checks++; if (wr_en !== 1'b0 || wr_dest !== 16'd0 || wr_val !== 16'd0) begin failures++; $display("FAIL rstmid_force act=%b/%h/%h exp=0/0/0", wr_en, wr_dest, wr_val); end
    req_valid = 3'b000;
    tick();
    rst = 1'b1;
    for (int c = 0; c < 2; c++) begin
      tick();
      checks++; if (wr_en !== 1'b0 || err_valid !== 1'b0) begin failures++; $display("FAIL rstmid_after c=%0d act=%b%b exp=00", c, wr_en, err_valid); end
    end
  endtask

  initial begin
    checks    = 0;
    failures  = 0;
    rst       = 1'b0;
    wr_stall  = 1'b0;
    req_valid = 3'b000;
    req_dest  = '0;
    req_data  = '0;
    test_reset();
    test_round_robin();
    test_wrap();
    test_illegal_dest();
    test_stall();
    test_reset_mid_op();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
